// File: rtl/inst_decode_pkg.sv
// Shared pipeline definitions: word/PC widths, RV32I opcodes, ID/EX register layout
// and the immediate generator used by fetch, decode and execute.
package inst_decode_pkg;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_PC_SIZE   = 2 * DEF_WORD_SIZE;
  localparam int DEF_REG_COUNT = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int ID_EX_W       = 192;

  // Bit offsets (LSB) of each ID/EX field, matching id_ex_t below.
  localparam int IDEX_PC_LSB   = 128;
  localparam int IDEX_RS1D_LSB = 96;
  localparam int IDEX_RS2D_LSB = 64;
  localparam int IDEX_IMM_LSB  = 32;
  localparam int IDEX_RS1_LSB  = 27;
  localparam int IDEX_RS2_LSB  = 22;
  localparam int IDEX_RD_LSB   = 17;
  localparam int IDEX_F3_LSB   = 14;
  localparam int IDEX_F7_LSB   = 7;
  localparam int IDEX_OPC_LSB  = 0;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
  } id_ex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr);
    logic [31:0] imm;
    imm = '0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:           imm = {instr[31:12], 12'b0};
      OPC_JAL:                      imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_BRANCH:                   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:                    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{instr[31]}}, instr[31:20]};
      default:                      imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/inst_decode_reg_file.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero and ignores writes.
module reg_file
  import inst_decode_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int REG_COUNT = DEF_REG_COUNT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  output logic [WORD_SIZE-1:0]  o_rdata1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic [WORD_SIZE-1:0]  o_rdata2,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0]  i_wdata
);

  logic [WORD_SIZE-1:0] regs_q [REG_COUNT];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : regs_q[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : regs_q[i_raddr2];

endmodule

// File: rtl/inst_decode.sv
// Decode stage: splits the IF/ID instruction into the ID/EX register, reads operands with
// writeback bypass, detects load-use hazards and flags unsupported opcodes.
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PC_SIZE   = DEF_PC_SIZE,
  parameter int REG_COUNT = DEF_REG_COUNT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [PC_SIZE+WORD_SIZE-1:0] i_if_id_reg,
  input  logic                        i_if_id_valid,
  input  logic                        i_flush,
  input  logic                        i_ex_mem_read,
  input  logic [4:0]                  i_ex_rd,
  input  logic                        i_wb_we,
  input  logic [4:0]                  i_wb_rd,
  input  logic [WORD_SIZE-1:0]        i_wb_data,
  output logic [ID_EX_W-1:0]          o_id_ex_reg,
  output logic                        o_id_ex_valid,
  output logic                        o_illegal,
  output logic                        o_stall_if
);

  // Flow control: an instruction is consumed at the edge where i_if_id_valid=1 and
  // o_stall_if=0; while o_stall_if=1 fetch holds i_if_id_reg and decode emits a bubble.
  logic [WORD_SIZE-1:0] instr;
  logic [PC_SIZE-1:0]   pc;
  logic [4:0]           rs1, rs2, rd;
  logic                 legal, uses_rs1, uses_rs2, hazard, wb_hit1, wb_hit2;
  logic [WORD_SIZE-1:0] rf_rdata1, rf_rdata2, rs1_data, rs2_data;
  id_ex_t               id_ex_d, id_ex_q;
  logic                 valid_d, valid_q, illegal_d, illegal_q;

  assign instr = i_if_id_reg[WORD_SIZE-1:0];
  assign pc    = i_if_id_reg[PC_SIZE+WORD_SIZE-1:WORD_SIZE];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rd    = instr[11:7];

  always_comb begin
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL:    ;
      OPC_JALR, OPC_LOAD, OPC_OPIMM:  uses_rs1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default:                        legal = 1'b0;
    endcase
  end

  reg_file #(.WORD_SIZE(WORD_SIZE), .REG_COUNT(REG_COUNT)) u_reg_file (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_raddr1 (rs1),
    .o_rdata1 (rf_rdata1),
    .i_raddr2 (rs2),
    .o_rdata2 (rf_rdata2),
    .i_we     (i_wb_we),
    .i_waddr  (i_wb_rd),
    .i_wdata  (i_wb_data)
  );

  // Same-cycle writeback is forwarded so decode never sees the stale register value.
  assign wb_hit1  = i_wb_we && (i_wb_rd != '0) && (i_wb_rd == rs1);
  assign wb_hit2  = i_wb_we && (i_wb_rd != '0) && (i_wb_rd == rs2);
  assign rs1_data = wb_hit1 ? i_wb_data : rf_rdata1;
  assign rs2_data = wb_hit2 ? i_wb_data : rf_rdata2;

  assign hazard     = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((uses_rs1 && (i_ex_rd == rs1)) || (uses_rs2 && (i_ex_rd == rs2)));
  assign o_stall_if = i_if_id_valid && !i_flush && hazard;

  always_comb begin
    id_ex_d   = '0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    if (i_if_id_valid && !i_flush && !hazard) begin
      if (legal) begin
        valid_d          = 1'b1;
        id_ex_d.pc       = pc;
        id_ex_d.rs1_data = rs1_data;
        id_ex_d.rs2_data = rs2_data;
        id_ex_d.imm      = imm_gen(instr);
        id_ex_d.rs1      = rs1;
        id_ex_d.rs2      = rs2;
        id_ex_d.rd       = rd;
        id_ex_d.funct3   = instr[14:12];
        id_ex_d.funct7   = instr[31:25];
        id_ex_d.opcode   = instr[6:0];
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      id_ex_q   <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      id_ex_q   <= id_ex_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_id_ex_reg   = id_ex_q;
  assign o_id_ex_valid = valid_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_inst_decode.sv
// Directed, table-driven bench for inst_decode: each row gives the inputs for one cycle
// plus the hand-computed stall, valid, illegal and operand/immediate results.
module tb_inst_decode;

  logic         i_clk;
  logic         i_rst;
  logic [95:0]  i_if_id_reg;
  logic         i_if_id_valid;
  logic         i_flush;
  logic         i_ex_mem_read;
  logic [4:0]   i_ex_rd;
  logic         i_wb_we;
  logic [4:0]   i_wb_rd;
  logic [31:0]  i_wb_data;
  logic [191:0] o_id_ex_reg;
  logic         o_id_ex_valid;
  logic         o_illegal;
  logic         o_stall_if;

  inst_decode dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_if_id_reg   (i_if_id_reg),
    .i_if_id_valid (i_if_id_valid),
    .i_flush       (i_flush),
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rd       (i_ex_rd),
    .i_wb_we       (i_wb_we),
    .i_wb_rd       (i_wb_rd),
    .i_wb_data     (i_wb_data),
    .o_id_ex_reg   (o_id_ex_reg),
    .o_id_ex_valid (o_id_ex_valid),
    .o_illegal     (o_illegal),
    .o_stall_if    (o_stall_if)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic        mem_read;
    logic [4:0]  ex_rd;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_stall;
    logic        exp_valid;
    logic        exp_illegal;
    logic [31:0] exp_rs1d;
    logic [31:0] exp_rs2d;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t         vecs[$];
  logic [191:0] exp_q[$];
  int           checks;
  int           failures;

  function automatic vec_t mk(input logic [63:0] pc, input logic [31:0] instr,
                              input logic valid, input logic flush, input logic mem_read,
                              input logic [4:0] ex_rd, input logic wb_we, input logic [4:0] wb_rd,
                              input logic [31:0] wb_data, input logic st, input logic ev,
                              input logic ei, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm);
    vec_t v;
    v.pc = pc; v.instr = instr; v.valid = valid; v.flush = flush; v.mem_read = mem_read;
    v.ex_rd = ex_rd; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.exp_stall = st; v.exp_valid = ev; v.exp_illegal = ei;
    v.exp_rs1d = r1; v.exp_rs2d = r2; v.exp_imm = imm;
    return v;
  endfunction

  // Expected ID/EX word: field bits come straight from the encoding, data and imm from the row.
  function automatic logic [191:0] pack(input vec_t v);
    return {v.pc, v.exp_rs1d, v.exp_rs2d, v.exp_imm, v.instr[19:15], v.instr[24:20],
            v.instr[11:7], v.instr[14:12], v.instr[31:25], v.instr[6:0]};
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // driver: inputs change 1 time unit after a rising edge, outputs sampled 1 unit later
  task automatic apply(input vec_t v, input string tag);
    i_if_id_reg   = {v.pc, v.instr};
    i_if_id_valid = v.valid;
    i_flush       = v.flush;
    i_ex_mem_read = v.mem_read;
    i_ex_rd       = v.ex_rd;
    i_wb_we       = v.wb_we;
    i_wb_rd       = v.wb_rd;
    i_wb_data     = v.wb_data;
    #1;
    chk({tag, " stall"}, {191'b0, o_stall_if}, {191'b0, v.exp_stall});
    exp_q.push_back(v.exp_valid ? pack(v) : 192'b0);
    @(posedge i_clk);
    #1;
    chk({tag, " valid"}, {191'b0, o_id_ex_valid}, {191'b0, v.exp_valid});
    chk({tag, " illegal"}, {191'b0, o_illegal}, {191'b0, v.exp_illegal});
    chk({tag, " id_ex"}, o_id_ex_reg, exp_q.pop_front());
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst = 1'b0; i_if_id_reg = '0; i_if_id_valid = 1'b0; i_flush = 1'b0;
    i_ex_mem_read = 1'b0; i_ex_rd = '0; i_wb_we = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset id_ex", o_id_ex_reg, 192'b0);
    chk("reset valid", {191'b0, o_id_ex_valid}, 192'b0);
    chk("reset illegal", {191'b0, o_illegal}, 192'b0);
    i_rst = 1'b1;

    //         pc          instr         v  f  mr exrd we wbrd wbdata         st ev ei rs1d          rs2d          imm
    vecs.push_back(mk(64'h100, 32'hFFB00093, 1, 0, 0, 0,  0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0,        32'hFFFFFFFB)); // addi x1,x0,-5
    vecs.push_back(mk(64'h104, 32'h00000013, 0, 0, 0, 0,  1, 1,  32'h10,       0, 0, 0, 32'h0,        32'h0,        32'h0));        // no instr, wb x1
    vecs.push_back(mk(64'h104, 32'h00528333, 1, 0, 0, 0,  1, 5,  32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0));        // add x6,x5,x5 bypass
    vecs.push_back(mk(64'h108, 32'h00138433, 1, 0, 1, 7,  1, 7,  32'h77,       1, 0, 0, 32'h0,        32'h0,        32'h0));        // add x8,x7,x1 load-use
    vecs.push_back(mk(64'h108, 32'h00138433, 1, 0, 0, 0,  0, 0,  32'h0,        0, 1, 0, 32'h77,       32'h10,       32'h0));        // held add released
    vecs.push_back(mk(64'h10C, 32'h00138463, 1, 1, 1, 1,  0, 0,  32'h0,        0, 0, 0, 32'h0,        32'h0,        32'h0));        // beq + hazard + flush
    vecs.push_back(mk(64'h10C, 32'h00138463, 1, 0, 1, 1,  0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0,        32'h0));        // beq rs2 hazard
    vecs.push_back(mk(64'h10C, 32'h00138463, 1, 0, 0, 0,  0, 0,  32'h0,        0, 1, 0, 32'h77,       32'h10,       32'h8));        // beq x7,x1,+8
    vecs.push_back(mk(64'h110, 32'h0000007F, 1, 0, 0, 0,  1, 0,  32'h1234,     0, 0, 1, 32'h0,        32'h0,        32'h0));        // illegal, wb x0
    vecs.push_back(mk(64'h114, 32'h000004B3, 1, 0, 0, 0,  1, 0,  32'h5555,     0, 1, 0, 32'h0,        32'h0,        32'h0));        // add x9,x0,x0
    vecs.push_back(mk(64'h118, 32'h12345537, 1, 0, 1, 8,  0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0,        32'h12345000)); // lui, no rs1 use
    vecs.push_back(mk(64'h11C, 32'hFE13AE23, 1, 0, 1, 5,  0, 0,  32'h0,        0, 1, 0, 32'h77,       32'h10,       32'hFFFFFFFC)); // sw x1,-4(x7)
    vecs.push_back(mk(64'h120, 32'hFF1FF0EF, 1, 0, 1, 31, 0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0,        32'hFFFFFFF0)); // jal x1,-16
    vecs.push_back(mk(64'hFFFFFFFF00000010, 32'h80000117, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0,    32'h0,        32'h80000000)); // auipc
    vecs.push_back(mk(64'h124, 32'h7FF0A183, 1, 0, 1, 31, 0, 0,  32'h0,        0, 1, 0, 32'h10,       32'h0,        32'h7FF));      // lw, rs2 unused
    vecs.push_back(mk(64'h128, 32'h00000067, 1, 0, 1, 0,  0, 0,  32'h0,        0, 1, 0, 32'h0,        32'h0,        32'h0));        // jalr, ex_rd=x0
    vecs.push_back(mk(64'h12C, 32'h00038067, 1, 0, 1, 7,  0, 0,  32'h0,        1, 0, 0, 32'h0,        32'h0,        32'h0));        // jalr rs1 hazard
    vecs.push_back(mk(64'h12C, 32'h00038067, 1, 0, 0, 7,  0, 0,  32'h0,        0, 1, 0, 32'h77,       32'h0,        32'h0));        // jalr released

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset mid-stream: x12 written, reset discards decode and clears registers.
    apply(mk(64'h200, 32'h0, 0, 0, 0, 0, 1, 12, 32'hABCD, 0, 0, 0, 32'h0, 32'h0, 32'h0), "rs0");
    apply(mk(64'h204, 32'h00C60733, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'hABCD, 32'hABCD, 32'h0), "rs1");
    i_rst = 1'b0;
    apply(mk(64'h208, 32'h00C60733, 1, 0, 0, 0, 1, 13, 32'h99, 0, 0, 0, 32'h0, 32'h0, 32'h0), "rs2");
    i_rst = 1'b1;
    apply(mk(64'h20C, 32'h00D60733, 1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 32'h0), "rs3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WORD_SIZE, 32, data/instruction width
  PC_SIZE, 64, PC width (2*WORD_SIZE)
  REG_COUNT, 32, architectural registers; x0 hardwired zero
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  i_clk  in  1  single clock, all state updates on rising edge
  i_rst  in  1  synchronous active-low reset
  i_if_id_reg  in  PC_SIZE+WORD_SIZE  {pc[95:32], instr[31:0]} from fetch
  i_if_id_valid  in  1  i_if_id_reg holds a real instruction
  i_flush  in  1  squash current decode (taken branch/jump)
  i_ex_mem_read  in  1  instruction now in EX is a load
  i_ex_rd  in  5  destination of instruction now in EX
  i_wb_we  in  1  writeback enable
  i_wb_rd  in  5  writeback destination
  i_wb_data  in  WORD_SIZE  writeback value
  o_id_ex_reg  out  192  ID/EX pipeline register (REQ-004)
  o_id_ex_valid  out  1  o_id_ex_reg holds a real instruction
  o_illegal  out  1  registered unsupported-opcode flag
  o_stall_if  out  1  combinational; fetch SHALL hold PC and IF/ID
REQ-003 Clock is i_clk, reset is i_rst; reset SHALL be synchronous and active-low.

Function
REQ-004 o_id_ex_reg fields SHALL be: pc[191:128], rs1_data[127:96], rs2_data[95:64], imm[63:32], rs1[31:27], rs2[26:22], rd[21:17], funct3[16:14], funct7[13:7], opcode[6:0].
REQ-005 Latency SHALL be one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-006 Supported opcodes SHALL be RV32I: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
REQ-007 imm SHALL be the sign-extended I, S, B, U or J immediate per opcode (B/J bit 0 = 0; U = instr[31:12]<<12); imm = 0 for OP.
REQ-008 rs1_data/rs2_data SHALL read the register file; reading x0 SHALL return 0.
REQ-009 Write-through: if i_wb_we && i_wb_rd!=0 && i_wb_rd==rsN in the same cycle, rsN_data SHALL be i_wb_data.
REQ-010 Writes with i_wb_rd==0 SHALL be ignored.
REQ-011 Load-use hazard: o_stall_if SHALL be 1 when i_if_id_valid && i_ex_mem_read && i_ex_rd!=0 && (i_ex_rd==rs1 for opcodes using rs1, or i_ex_rd==rs2 for BRANCH/STORE/OP).
REQ-012 On hazard, next cycle SHALL be a bubble: o_id_ex_valid=0, o_id_ex_reg=0, o_illegal=0; the held instruction is decoded when the hazard clears.
REQ-013 i_flush SHALL override everything: next output is a bubble and o_stall_if SHALL be 0 that cycle.
REQ-014 i_if_id_valid=0 SHALL produce a bubble.
REQ-015 Unsupported opcode with valid input: o_illegal=1, o_id_ex_valid=0, o_id_ex_reg=0.
REQ-016 Register-file writes SHALL proceed regardless of stall/flush/valid.

Reset
REQ-017 While i_rst=0 at an edge: o_id_ex_reg=0, o_id_ex_valid=0, o_illegal=0, all registers=0; writeback ignored.
REQ-018 Reset asserted mid-operation SHALL discard the in-flight decode; first instruction after release decodes normally with one-cycle latency.

Structure
REQ-019 WORD_SIZE, PC_SIZE, opcode constants and ID/EX field offsets SHALL live in a shared header used by fetch, decode and execute.
REQ-020 Register file SHALL be sub-module reg_file (2 async read ports, 1 sync write port, sync active-low reset, x0 = 0).

Verification
REQ-021 addi x1,x0,-5 (0xFFB00093), pc=0x100 -> next cycle valid=1, pc=0x100, rd=1, rs1_data=0, imm=0xFFFFFFFB, opcode=0010011.
REQ-022 wb x5=0xDEADBEEF same cycle as decode of add x6,x5,x5 -> rs1_data=rs2_data=0xDEADBEEF (bypass).
REQ-023 EX load rd=x7, decode add x8,x7,x1 -> o_stall_if=1 same cycle, bubble next; hazard released -> add decoded with valid=1.
REQ-024 i_flush=1 together with hazard and valid beq -> o_stall_if=0, next output bubble.
REQ-025 opcode 1111111 -> o_illegal=1, valid=0; wb to x0 with 0x1234 then read x0 -> 0.
REQ-026 i_rst=0 mid-stream -> all outputs 0 next edge; registers read 0 after release.
